// File: rtl/data_mem_split.sv
// data_mem_split: byte-addressable little-endian data memory with word-wide memory-mapped IO.
// Latency: response 1 cycle after acceptance; 2 cycles for accesses that straddle a word boundary.
// Backpressure: req_ready drops for the single SPLIT cycle of a straddling access, otherwise 1/cycle.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (accepted when both high)
//   req_we, req_funct3         store/load select and access size/extension (RISC-V load/store funct3)
//   req_addr, req_wdata        byte address and store data (low byte/halfword used for sb/sh)
//   resp_valid                 one-cycle completion pulse, responses in acceptance order
//   resp_rdata, resp_err       load data (0 for stores and errors) and rejection flag
//   io_in, io_out              N_IO packed 32-bit IO words, channel i at bits [32i+31:32i]
module data_mem_split #(
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned N_IO    = 2,
   parameter logic [31:0] IO_BASE = 32'hFFFF_FF00
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [2:0]          req_funct3,
   input  logic [31:0]         req_addr,
   input  logic [31:0]         req_wdata,
   output logic                resp_valid,
   output logic [31:0]         resp_rdata,
   output logic                resp_err,
   input  logic [32*N_IO-1:0]  io_in,
   output logic [32*N_IO-1:0]  io_out
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic {
      IDLE  = 1'b0,
      SPLIT = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t              r_state;
   logic                r_resp_valid;
   logic                r_resp_err;
   logic [31:0]         r_resp_rdata;
   logic [32*N_IO-1:0]  r_io_out;

   // Context carried from the first to the second half of a split access.
   // Store data and load bytes are kept lane-ordered (byte lane 0..3 of a
   // memory word) so the second half only has to pick lanes by r_en1.
   logic [AW-1:0]       r_word1;
   logic [3:0]          r_en1;
   logic [31:0]         r_wlane;
   logic [31:0]         r_lanebuf;
   logic [1:0]          r_off;
   logic [2:0]          r_funct3;
   logic                r_we;

   // Byte-lane memory; deliberately not reset.
   logic [7:0]          r_mem [4][DEPTH];

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic                w_accept;
   logic [1:0]          w_off;
   logic [3:0]          w_size;
   logic [3:0]          w_lane_end;
   logic [32:0]         w_end;
   logic                w_f3_bad;
   logic                w_in_mem;
   logic                w_in_io;
   logic                w_err;
   logic                w_is_mem;
   logic                w_is_io;
   logic                w_split;
   logic [3:0]          w_en0;
   logic [3:0]          w_en1;
   logic [31:0]         w_wlane;
   logic [29:0]         w_io_idx;
   logic [31:0]         w_io_rdata;

   assign req_ready = rst_n && (r_state == IDLE);
   assign w_accept  = req_valid && req_ready;

   always_comb begin
      w_off = req_addr[1:0];

      case (req_funct3[1:0])
         2'd0:    w_size = 4'd1;
         2'd1:    w_size = 4'd2;
         default: w_size = 4'd4;
      endcase

      // One past the last lane touched, counted from lane 0 of word w;
      // values above 4 spill into word w+1.
      w_lane_end = {2'b00, w_off} + w_size;

      w_f3_bad = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) ||
                 (req_funct3 == 3'd7) || (req_we && (req_funct3 > 3'd2));

      // 33-bit arithmetic so accesses near 0xFFFF_FFFF cannot wrap into range.
      w_end    = {1'b0, req_addr} + {29'd0, w_size} - 33'd1;
      w_in_mem = w_end < (33'(DEPTH) << 2);
      w_in_io  = (req_funct3 == 3'd2) && (w_off == 2'd0) &&
                 ({1'b0, req_addr} >= {1'b0, IO_BASE}) &&
                 ({1'b0, req_addr} <  ({1'b0, IO_BASE} + (33'(N_IO) << 2)));

      w_err    = w_f3_bad || !(w_in_mem || w_in_io);
      w_is_mem = !w_err && w_in_mem;
      w_is_io  = !w_err && !w_in_mem && w_in_io;
      w_split  = w_is_mem && (w_lane_end > 4'd4);

      w_en0 = 4'b0000;
      w_en1 = 4'b0000;
      for (int l = 0; l < 4; l++) begin
         w_en0[l] = (4'(l) >= {2'b00, w_off}) && (4'(l) < w_lane_end);
         w_en1[l] = (4'(l) + 4'd4) < w_lane_end;
      end

      // Rotate store data so request byte k lands in lane (off+k) mod 4.
      case (w_off)
         2'd0:    w_wlane = req_wdata;
         2'd1:    w_wlane = {req_wdata[23:0], req_wdata[31:24]};
         2'd2:    w_wlane = {req_wdata[15:0], req_wdata[31:16]};
         default: w_wlane = {req_wdata[7:0],  req_wdata[31:8]};
      endcase

      w_io_idx = req_addr[31:2] - IO_BASE[31:2];
   end

   always_comb begin
      w_io_rdata = 32'd0;
      for (int i = 0; i < N_IO; i++) begin
         if (w_io_idx == 30'(i)) begin
            w_io_rdata = io_in[32*i +: 32];
         end
      end
   end

   // ------------------------------------------------------------------
   // Memory port: the accepting edge in IDLE or the SPLIT cycle owns it,
   // never both, so one address and one set of lane enables suffice.
   // ------------------------------------------------------------------
   logic [AW-1:0]       w_mem_word;
   logic [3:0]          w_mem_we;
   logic [31:0]         w_mem_wlane;
   logic [31:0]         w_rd_lanes;
   logic [31:0]         w_merge;

   always_comb begin
      if (r_state == SPLIT) begin
         w_mem_word  = r_word1;
         w_mem_we    = r_we ? r_en1 : 4'b0000;
         w_mem_wlane = r_wlane;
      end else begin
         w_mem_word  = req_addr[AW+1:2];
         w_mem_we    = (w_accept && w_is_mem && req_we) ? w_en0 : 4'b0000;
         w_mem_wlane = w_wlane;
      end
   end

   always_comb begin
      w_rd_lanes = {r_mem[3][w_mem_word], r_mem[2][w_mem_word],
                    r_mem[1][w_mem_word], r_mem[0][w_mem_word]};
      // Second half of a split load: lanes of word w+1 come from the array,
      // the rest from what the first half captured.
      w_merge = r_lanebuf;
      for (int l = 0; l < 4; l++) begin
         if (r_en1[l]) begin
            w_merge[8*l +: 8] = w_rd_lanes[8*l +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int l = 0; l < 4; l++) begin
         if (w_mem_we[l]) begin
            r_mem[l][w_mem_word] <= w_mem_wlane[8*l +: 8];
         end
      end
   end

   // ------------------------------------------------------------------
   // Load result formatting from lane-ordered bytes
   // ------------------------------------------------------------------
   function automatic logic [31:0] f_load(input logic [31:0] lanes,
                                          input logic [1:0]  off,
                                          input logic [2:0]  f3);
      logic [31:0] raw;
      // Undo the lane rotation: request byte k comes from lane (off+k) mod 4.
      case (off)
         2'd0:    raw = lanes;
         2'd1:    raw = {lanes[7:0],  lanes[31:8]};
         2'd2:    raw = {lanes[15:0], lanes[31:16]};
         default: raw = {lanes[23:0], lanes[31:24]};
      endcase
      case (f3)
         3'd0:    f_load = {{24{raw[7]}},  raw[7:0]};
         3'd1:    f_load = {{16{raw[15]}}, raw[15:0]};
         3'd4:    f_load = {24'd0, raw[7:0]};
         3'd5:    f_load = {16'd0, raw[15:0]};
         default: f_load = raw;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Control FSM, response and IO registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_io_out     <= '0;
         r_word1      <= '0;
         r_en1        <= 4'b0000;
         r_wlane      <= 32'd0;
         r_lanebuf    <= 32'd0;
         r_off        <= 2'd0;
         r_funct3     <= 3'd0;
         r_we         <= 1'b0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= 32'd0;

         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  if (w_err) begin
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                  end else if (w_is_io) begin
                     r_resp_valid <= 1'b1;
                     if (req_we) begin
                        for (int i = 0; i < N_IO; i++) begin
                           if (w_io_idx == 30'(i)) begin
                              r_io_out[32*i +: 32] <= req_wdata;
                           end
                        end
                     end else begin
                        r_resp_rdata <= w_io_rdata;
                     end
                  end else if (w_split) begin
                     // First half already handled by the memory port this edge.
                     r_state   <= SPLIT;
                     r_word1   <= w_mem_word + AW'(1);
                     r_en1     <= w_en1;
                     r_wlane   <= w_wlane;
                     r_lanebuf <= w_rd_lanes;
                     r_off     <= w_off;
                     r_funct3  <= req_funct3;
                     r_we      <= req_we;
                  end else begin
                     r_resp_valid <= 1'b1;
                     if (!req_we) begin
                        r_resp_rdata <= f_load(w_rd_lanes, w_off, req_funct3);
                     end
                  end
               end
            end

            SPLIT: begin
               r_state      <= IDLE;
               r_resp_valid <= 1'b1;
               if (!r_we) begin
                  r_resp_rdata <= f_load(w_merge, r_off, r_funct3);
               end
            end

            default: r_state <= IDLE;
         endcase
      end
   end

   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;
   assign io_out     = r_io_out;

endmodule

// File: tb/tb_data_mem_split.sv
// tb_data_mem_split: directed scoreboard bench for data_mem_split.
// Stimulus pushes hand-computed responses (data, error, arrival cycle) into a queue;
// an independent monitor pops and compares on every resp_valid.
module tb_data_mem_split;

   localparam int          DEPTH   = 64;
   localparam int          N_IO    = 2;
   localparam logic [31:0] IO_BASE = 32'hFFFF_FF00;

   localparam logic [2:0] F_B  = 3'd0;
   localparam logic [2:0] F_H  = 3'd1;
   localparam logic [2:0] F_W  = 3'd2;
   localparam logic [2:0] F_BU = 3'd4;
   localparam logic [2:0] F_HU = 3'd5;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                req_valid = 1'b0;
   logic                req_ready;
   logic                req_we = 1'b0;
   logic [2:0]          req_funct3 = 3'd0;
   logic [31:0]         req_addr = 32'd0;
   logic [31:0]         req_wdata = 32'd0;
   logic                resp_valid;
   logic [31:0]         resp_rdata;
   logic                resp_err;
   logic [32*N_IO-1:0]  io_in = '0;
   logic [32*N_IO-1:0]  io_out;

   data_mem_split #(.DEPTH(DEPTH), .N_IO(N_IO), .IO_BASE(IO_BASE)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .io_in      (io_in),
      .io_out     (io_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;
   int next_id  = 0;

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int          cyc;
      int          id;
   } exp_t;

   exp_t sb_q[$];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest outstanding expectation,
   // including the cycle in which it appears.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (resp_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_resp: got resp_valid=1 err=%0b rdata=%h, required no response",
                     resp_err, resp_rdata);
         end else begin
            e = sb_q.pop_front();
            if (resp_err !== e.err || resp_rdata !== e.rdata || cyc != e.cyc) begin
               failures++;
               $display("FAIL resp%0d: got err=%0b rdata=%h cycle=%0d, required err=%0b rdata=%h cycle=%0d",
                        e.id, resp_err, resp_rdata, cyc, e.err, e.rdata, e.cyc);
            end
         end
      end
   end

   // Issue one request; lat = cycles from acceptance to resp_valid (1 or 2).
   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic e, input logic [31:0] rd,
                        input int lat);
      int   n;
      exp_t x;
      n          = 0;
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wd;
      while (!req_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!req_ready) begin
         check("ready_timeout", {63'd0, req_ready}, 64'd1);
         req_valid = 1'b0;
      end else begin
         x.err   = e;
         x.rdata = rd;
         x.cyc   = cyc + lat;
         x.id    = next_id;
         next_id++;
         sb_q.push_back(x);
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         if (lat == 2) begin
            check("split_ready_low", {63'd0, req_ready}, 64'd0);
            @(posedge clk);
            #1;
            check("split_ready_back", {63'd0, req_ready}, 64'd1);
         end
      end
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin : stim
      int n;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("rst_resp_err",   {63'd0, resp_err},   64'd0);
      check("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
      check("rst_req_ready",  {63'd0, req_ready},  64'd0);
      check("rst_io_out",     io_out,              64'd0);
      rst_n = 1'b1;
      #1;
      check("ready_after_rst", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;

      // Aligned word store and read-after-write
      issue(1, F_W,  32'h10, 32'h11223344, 0, 32'h0,        1);
      issue(0, F_W,  32'h10, 32'h0,        0, 32'h11223344, 1);

      // Byte / halfword stores and extension
      issue(1, F_W,  32'h20, 32'h00000037, 0, 32'h0,        1);
      issue(1, F_B,  32'h21, 32'h12345680, 0, 32'h0,        1);
      issue(0, F_B,  32'h21, 32'h0,        0, 32'hFFFFFF80, 1);
      issue(0, F_BU, 32'h21, 32'h0,        0, 32'h00000080, 1);
      issue(0, F_H,  32'h20, 32'h0,        0, 32'hFFFF8037, 1);
      issue(0, F_HU, 32'h20, 32'h0,        0, 32'h00008037, 1);
      issue(1, F_H,  32'h22, 32'hBEEF7F01, 0, 32'h0,        1);
      issue(0, F_W,  32'h20, 32'h0,        0, 32'h7F018037, 1);
      issue(0, F_H,  32'h22, 32'h0,        0, 32'h00007F01, 1);

      // Split word / halfword accesses
      issue(1, F_W,  32'h0E, 32'hAABBCCDD, 0, 32'h0,        2);
      issue(0, F_W,  32'h0E, 32'h0,        0, 32'hAABBCCDD, 2);
      issue(0, F_BU, 32'h10, 32'h0,        0, 32'h000000BB, 1);
      issue(0, F_HU, 32'h0F, 32'h0,        0, 32'h0000BBCC, 2);
      issue(0, F_W,  32'h10, 32'h0,        0, 32'h1122AABB, 1);
      issue(1, F_H,  32'h13, 32'h00009966, 0, 32'h0,        2);
      issue(0, F_H,  32'h13, 32'h0,        0, 32'hFFFF9966, 2);
      issue(0, F_BU, 32'h14, 32'h0,        0, 32'h00000099, 1);
      issue(0, F_W,  32'h10, 32'h0,        0, 32'h6622AABB, 1);

      // Errors and top-of-memory boundary
      issue(1, F_W,  32'hFC, 32'hDEADBEEF, 0, 32'h0,        1);
      issue(1, F_W,  32'hFE, 32'h12345678, 1, 32'h0,        1);
      issue(0, F_W,  32'hFE, 32'h0,        1, 32'h0,        1);
      issue(0, F_W,  32'hFC, 32'h0,        0, 32'hDEADBEEF, 1);
      issue(0, F_B,  32'hFF, 32'h0,        0, 32'hFFFFFFDE, 1);
      issue(0, F_B,  32'h100, 32'h0,       1, 32'h0,        1);
      issue(0, F_HU, 32'hFF, 32'h0,        1, 32'h0,        1);
      issue(0, 3'd3, 32'h10, 32'h0,        1, 32'h0,        1);
      issue(0, 3'd7, 32'h10, 32'h0,        1, 32'h0,        1);
      issue(1, 3'd4, 32'h10, 32'h0,        1, 32'h0,        1);
      issue(0, F_W,  32'h10, 32'h0,        0, 32'h6622AABB, 1);

      // Memory-mapped IO
      io_in = {32'hCAFEF00D, 32'h01234567};
      issue(0, F_W,  IO_BASE + 32'd4, 32'h0, 0, 32'hCAFEF00D, 1);
      io_in = {32'h00000000, 32'h01234567};
      issue(0, F_W,  IO_BASE,         32'h0, 0, 32'h01234567, 1);
      issue(1, F_W,  IO_BASE, 32'h0000005A,  0, 32'h0,        1);
      check("io_out_sw0", io_out, {32'h0, 32'h0000005A});
      issue(1, F_H,  IO_BASE, 32'h0000FFFF,  1, 32'h0,        1);
      check("io_out_sh_err", io_out, {32'h0, 32'h0000005A});
      issue(0, F_W,  IO_BASE + 32'd8, 32'h0, 1, 32'h0,        1);
      issue(0, F_W,  IO_BASE + 32'd2, 32'h0, 1, 32'h0,        1);
      issue(0, F_B,  IO_BASE,         32'h0, 1, 32'h0,        1);
      issue(1, F_W,  IO_BASE + 32'd4, 32'h77, 0, 32'h0,       1);
      check("io_out_sw1", io_out, {32'h00000077, 32'h0000005A});

      // Reset in the middle of a split store
      issue(1, F_W,  32'h24, 32'h0,        0, 32'h0,        1);
      issue(1, F_W,  32'h28, 32'h0,        0, 32'h0,        1);
      repeat (3) @(posedge clk);
      #1;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = F_W;
      req_addr   = 32'h26;
      req_wdata  = 32'h55667788;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("midsplit_ready_low", {63'd0, req_ready}, 64'd0);
      rst_n = 1'b0;
      #1;
      check("midsplit_io_out",     io_out,              64'd0);
      check("midsplit_resp_valid", {63'd0, resp_valid}, 64'd0);
      check("midsplit_req_ready",  {63'd0, req_ready},  64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      check("ready_after_rst2", {63'd0, req_ready}, 64'd1);
      @(posedge clk);
      #1;
      issue(0, F_HU, 32'h26, 32'h0,        0, 32'h00007788, 1);
      issue(0, F_HU, 32'h28, 32'h0,        0, 32'h00000000, 1);
      issue(0, F_W,  32'h24, 32'h0,        0, 32'h77880000, 1);

      // Idle cycles, then all expectations must have been consumed
      repeat (3) @(posedge clk);
      #1;
      n = 0;
      while (sb_q.size() != 0 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
